// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory port.
// slave  : the arbiter's view (requests in, responses and memory request out).
// master : the environment's view (requesters plus memory).
interface mem_arbiter_if;
    // program-fetch port
    logic        CS_P;
    logic [31:0] ADDR_Prog;
    logic [31:0] Prog_BUS_READ;
    logic        prog_ready;
    logic        stall_prog;
    // data port
    logic        CS;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        data_ready;
    logic        stall_data;
    // single-port memory
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  CS_P, ADDR_Prog, CS, WE, ADDR, Data_BUS_WRITE, mem_rdata,
        output Prog_BUS_READ, prog_ready, stall_prog,
        output Data_BUS_READ, data_ready, stall_data,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output CS_P, ADDR_Prog, CS, WE, ADDR, Data_BUS_WRITE, mem_rdata,
        input  Prog_BUS_READ, prog_ready, stall_prog,
        input  Data_BUS_READ, data_ready, stall_data,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (program fetch, data load/store) in front of a
// single-port memory with fixed read latency MEM_LAT (1..15).
// One access at a time: IDLE (arbitrate + latch) -> BUSY x MEM_LAT -> RESP.
// Under continuous contention the prog_owed flag makes grants alternate
// so the fetch side cannot be starved by back-to-back data traffic.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Counter is loaded with MEM_LAT-1 so BUSY spans exactly MEM_LAT cycles.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_owed;
    logic        r_gnt_prog;
    logic        r_gnt_data;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_prog_rd;
    logic [31:0] r_data_rd;

    logic        w_pick_prog;
    logic        w_start;
    logic        w_done;
    logic        w_busy;
    logic        w_resp;

    // Arbitration and phase decode.
    always_comb begin
        w_pick_prog = bus.CS_P & (~bus.CS | r_owed);
        w_start     = (r_state == IDLE) & (bus.CS_P | bus.CS);
        w_done      = (r_state == BUSY) & (r_cnt == 4'd0);
        w_busy      = (r_state == BUSY);
        w_resp      = (r_state == RESP);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = BUSY;
            BUSY:    if (w_done)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Transaction latch, latency counter, fairness flag and read-back registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_owed     <= 1'b0;
            r_gnt_prog <= 1'b0;
            r_gnt_data <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_prog_rd  <= 32'd0;
            r_data_rd  <= 32'd0;
        end else if (w_start) begin
            r_gnt_prog <= w_pick_prog;
            r_gnt_data <= ~w_pick_prog;
            r_addr     <= w_pick_prog ? bus.ADDR_Prog : bus.ADDR;
            // WE only matters for a data grant, which implies CS was high.
            r_we       <= ~w_pick_prog & bus.WE;
            r_wdata    <= w_pick_prog ? 32'd0 : bus.Data_BUS_WRITE;
            r_cnt      <= LAT_M1;
            // Data beat a waiting fetch: owe the fetch the next slot.
            r_owed     <= w_pick_prog ? 1'b0 : bus.CS_P;
        end else if (w_busy) begin
            if (r_cnt == 4'd0) begin
                if (!r_we && r_gnt_prog) r_prog_rd <= bus.mem_rdata;
                if (!r_we && r_gnt_data) r_data_rd <= bus.mem_rdata;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign bus.mem_cs        = w_busy;
    assign bus.mem_we        = w_busy & r_we;
    assign bus.mem_addr      = w_busy ? r_addr  : 32'd0;
    assign bus.mem_wdata     = w_busy ? r_wdata : 32'd0;
    assign bus.prog_ready    = w_resp & r_gnt_prog;
    assign bus.data_ready    = w_resp & r_gnt_data;
    assign bus.stall_prog    = bus.CS_P & ~bus.prog_ready;
    assign bus.stall_data    = bus.CS   & ~bus.data_ready;
    assign bus.Prog_BUS_READ = r_prog_rd;
    assign bus.Data_BUS_READ = r_data_rd;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled on
// the falling edge, so each sample reflects the state after the prior rise.
module tb_mem_arbiter;
    logic CLK;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();
    mem_arbiter_if bus15 ();

    mem_arbiter #(.MEM_LAT(2))  u_dut   (.CLK(CLK), .reset(reset), .bus(bus));
    mem_arbiter #(.MEM_LAT(1))  u_dut1  (.CLK(CLK), .reset(reset), .bus(bus1));
    mem_arbiter #(.MEM_LAT(15)) u_dut15 (.CLK(CLK), .reset(reset), .bus(bus15));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if ({bus.mem_cs, bus.mem_we, bus.prog_ready, bus.data_ready} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.mem_cs, bus.mem_we, bus.prog_ready, bus.data_ready});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.Prog_BUS_READ, bus.Data_BUS_READ} !== 128'd0) begin
            n_errors++; $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.Prog_BUS_READ, bus.Data_BUS_READ});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        bus.CS_P = 1'b1; bus.ADDR_Prog = 32'h40; bus.mem_rdata = 32'h064F;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            n_checks++;
            if ({bus.mem_cs, bus.mem_we, bus.prog_ready, bus.stall_prog} !== 4'b1001) begin
                n_errors++; $display("FAIL fetch_busy%0d: got cs/we/rdy/stall %b expected 1001", c, {bus.mem_cs, bus.mem_we, bus.prog_ready, bus.stall_prog});
            end
            n_checks++;
            if (bus.mem_addr !== 32'h40) begin
                n_errors++; $display("FAIL fetch_addr%0d: got %h expected 00000040", c, bus.mem_addr);
            end
        end
        cyc();
        n_checks++;
        if ({bus.mem_cs, bus.prog_ready, bus.data_ready, bus.stall_prog} !== 4'b0100) begin
            n_errors++; $display("FAIL fetch_resp: got cs/prdy/drdy/stall %b expected 0100", {bus.mem_cs, bus.prog_ready, bus.data_ready, bus.stall_prog});
        end
        n_checks++;
        if (bus.Prog_BUS_READ !== 32'h064F) begin
            n_errors++; $display("FAIL fetch_data: got %h expected 0000064f", bus.Prog_BUS_READ);
        end
        bus.CS_P = 1'b0;
        cyc();
        n_checks++;
        if ({bus.prog_ready, bus.mem_cs} !== 2'b00) begin
            n_errors++; $display("FAIL fetch_pulse_end: got %b expected 00", {bus.prog_ready, bus.mem_cs});
        end
    endtask

    task automatic test_load();
        bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = 32'h200; bus.mem_rdata = 32'h1234;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            n_checks++;
            if ({bus.mem_cs, bus.mem_we, bus.stall_data} !== 3'b101 || bus.mem_addr !== 32'h200) begin
                n_errors++; $display("FAIL load_busy%0d: got cs/we/stall %b addr %h expected 101 00000200", c, {bus.mem_cs, bus.mem_we, bus.stall_data}, bus.mem_addr);
            end
        end
        cyc();
        n_checks++;
        if ({bus.data_ready, bus.prog_ready} !== 2'b10 || bus.Data_BUS_READ !== 32'h1234) begin
            n_errors++; $display("FAIL load_resp: got rdy %b data %h expected 10 00001234", {bus.data_ready, bus.prog_ready}, bus.Data_BUS_READ);
        end
        n_checks++;
        if (bus.Prog_BUS_READ !== 32'h064F) begin
            n_errors++; $display("FAIL load_prog_hold: got %h expected 0000064f", bus.Prog_BUS_READ);
        end
        bus.CS = 1'b0;
        cyc();
    endtask

    task automatic test_store();
        bus.CS = 1'b1; bus.WE = 1'b1; bus.ADDR = 32'h100; bus.Data_BUS_WRITE = 32'h22B4; bus.mem_rdata = 32'hDEAD;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            n_checks++;
            if ({bus.mem_cs, bus.mem_we} !== 2'b11 || bus.mem_wdata !== 32'h22B4 || bus.mem_addr !== 32'h100) begin
                n_errors++; $display("FAIL store_busy%0d: got cs/we %b wdata %h addr %h expected 11 000022b4 00000100", c, {bus.mem_cs, bus.mem_we}, bus.mem_wdata, bus.mem_addr);
            end
        end
        cyc();
        n_checks++;
        if ({bus.data_ready, bus.mem_cs} !== 2'b10) begin
            n_errors++; $display("FAIL store_resp: got rdy/cs %b expected 10", {bus.data_ready, bus.mem_cs});
        end
        n_checks++;
        if (bus.Data_BUS_READ !== 32'h1234) begin
            n_errors++; $display("FAIL store_no_readback: got %h expected 00001234", bus.Data_BUS_READ);
        end
        bus.CS = 1'b0;
        cyc();
    endtask

    task automatic test_we_ignored();
        bus.CS = 1'b0; bus.CS_P = 1'b0; bus.WE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_checks++;
            if ({bus.mem_cs, bus.mem_we, bus.data_ready, bus.stall_data} !== 4'b0000) begin
                n_errors++; $display("FAIL we_ignored%0d: got %b expected 0000", c, {bus.mem_cs, bus.mem_we, bus.data_ready, bus.stall_data});
            end
        end
        bus.WE = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_rdy, exp_prog;
        bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = 32'h200;
        bus.CS_P = 1'b1; bus.ADDR_Prog = 32'h40; bus.mem_rdata = 32'h7777;
        for (int c = 0; c < 16; c++) begin
            cyc();
            exp_rdy  = (c % 4 == 2);
            exp_prog = ((c / 4) % 2 == 1);
            n_checks++;
            if ((bus.data_ready | bus.prog_ready) !== exp_rdy) begin
                n_errors++; $display("FAIL cont_ready_c%0d: got %b expected %b", c, bus.data_ready | bus.prog_ready, exp_rdy);
            end
            if (exp_rdy) begin
                n_checks++;
                if (bus.prog_ready !== exp_prog) begin
                    n_errors++; $display("FAIL cont_grant_c%0d: got prog %b expected %b", c, bus.prog_ready, exp_prog);
                end
            end
            if (c % 4 < 2) begin
                n_checks++;
                if (bus.mem_addr !== (exp_prog ? 32'h40 : 32'h200)) begin
                    n_errors++; $display("FAIL cont_addr_c%0d: got %h expected %h", c, bus.mem_addr, exp_prog ? 32'h40 : 32'h200);
                end
            end
            n_checks++;
            if ({bus.stall_prog, bus.stall_data} !== {!(exp_rdy && exp_prog), !(exp_rdy && !exp_prog)}) begin
                n_errors++; $display("FAIL cont_stall_c%0d: got %b expected %b", c, {bus.stall_prog, bus.stall_data}, {!(exp_rdy && exp_prog), !(exp_rdy && !exp_prog)});
            end
        end
        bus.CS = 1'b0; bus.CS_P = 1'b0;
        cyc();
    endtask

    task automatic test_drop();
        bus.CS_P = 1'b1; bus.ADDR_Prog = 32'h80; bus.mem_rdata = 32'h5555;
        cyc();
        n_checks++;
        if (bus.mem_addr !== 32'h80 || bus.mem_cs !== 1'b1) begin
            n_errors++; $display("FAIL drop_busy1: got cs %b addr %h expected 1 00000080", bus.mem_cs, bus.mem_addr);
        end
        bus.CS_P = 1'b0; bus.ADDR_Prog = 32'h999;
        cyc();
        n_checks++;
        if (bus.mem_addr !== 32'h80 || {bus.mem_cs, bus.stall_prog} !== 2'b10) begin
            n_errors++; $display("FAIL drop_busy2: got cs/stall %b addr %h expected 10 00000080", {bus.mem_cs, bus.stall_prog}, bus.mem_addr);
        end
        cyc();
        n_checks++;
        if (bus.prog_ready !== 1'b1 || bus.Prog_BUS_READ !== 32'h5555) begin
            n_errors++; $display("FAIL drop_resp: got rdy %b data %h expected 1 00005555", bus.prog_ready, bus.Prog_BUS_READ);
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_checks++;
            if ({bus.prog_ready, bus.mem_cs} !== 2'b00) begin
                n_errors++; $display("FAIL drop_idle%0d: got rdy/cs %b expected 00", c, {bus.prog_ready, bus.mem_cs});
            end
        end
    endtask

    task automatic test_reset_busy();
        bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = 32'h300;
        bus.CS_P = 1'b1; bus.ADDR_Prog = 32'h44; bus.mem_rdata = 32'hABCD;
        cyc();
        n_checks++;
        if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h300) begin
            n_errors++; $display("FAIL rstb_busy: got cs %b addr %h expected 1 00000300", bus.mem_cs, bus.mem_addr);
        end
        reset = 1'b1;
        cyc();
        n_checks++;
        if ({bus.mem_cs, bus.mem_we, bus.prog_ready, bus.data_ready} !== 4'b0000) begin
            n_errors++; $display("FAIL rstb_ctrl: got %b expected 0000", {bus.mem_cs, bus.mem_we, bus.prog_ready, bus.data_ready});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.Prog_BUS_READ, bus.Data_BUS_READ} !== 128'd0) begin
            n_errors++; $display("FAIL rstb_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.Prog_BUS_READ, bus.Data_BUS_READ});
        end
        reset = 1'b0;
        cyc();
        // owed flag cleared by reset, so data wins again
        n_checks++;
        if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h300 || {bus.prog_ready, bus.data_ready} !== 2'b00) begin
            n_errors++; $display("FAIL rstb_rearb: got cs %b addr %h rdy %b expected 1 00000300 00", bus.mem_cs, bus.mem_addr, {bus.prog_ready, bus.data_ready});
        end
        cyc();
        cyc();
        n_checks++;
        if ({bus.data_ready, bus.prog_ready} !== 2'b10 || bus.Data_BUS_READ !== 32'hABCD) begin
            n_errors++; $display("FAIL rstb_resp: got rdy %b data %h expected 10 0000abcd", {bus.data_ready, bus.prog_ready}, bus.Data_BUS_READ);
        end
        bus.CS = 1'b0; bus.CS_P = 1'b0;
        cyc();
    endtask

    task automatic test_latency();
        bus1.CS_P = 1'b1;  bus1.ADDR_Prog = 32'h10;  bus1.mem_rdata = 32'h1111;
        bus15.CS_P = 1'b1; bus15.ADDR_Prog = 32'h20; bus15.mem_rdata = 32'hFFFF;
        for (int c = 0; c < 18; c++) begin
            cyc();
            n_checks++;
            if ({bus1.mem_cs, bus1.prog_ready} !== {c < 1, c == 1}) begin
                n_errors++; $display("FAIL lat1_c%0d: got cs/rdy %b expected %b", c, {bus1.mem_cs, bus1.prog_ready}, {c < 1, c == 1});
            end
            n_checks++;
            if ({bus15.mem_cs, bus15.prog_ready} !== {c < 15, c == 15}) begin
                n_errors++; $display("FAIL lat15_c%0d: got cs/rdy %b expected %b", c, {bus15.mem_cs, bus15.prog_ready}, {c < 15, c == 15});
            end
            if (c == 1)  bus1.CS_P = 1'b0;
            if (c == 15) bus15.CS_P = 1'b0;
        end
        n_checks++;
        if (bus1.Prog_BUS_READ !== 32'h1111 || bus15.Prog_BUS_READ !== 32'hFFFF) begin
            n_errors++; $display("FAIL lat_data: got %h %h expected 00001111 0000ffff", bus1.Prog_BUS_READ, bus15.Prog_BUS_READ);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.CS_P = 1'b0; bus.ADDR_Prog = '0; bus.CS = 1'b0; bus.WE = 1'b0;
        bus.ADDR = '0; bus.Data_BUS_WRITE = '0; bus.mem_rdata = '0;
        bus1.CS_P = 1'b0; bus1.ADDR_Prog = '0; bus1.CS = 1'b0; bus1.WE = 1'b0;
        bus1.ADDR = '0; bus1.Data_BUS_WRITE = '0; bus1.mem_rdata = '0;
        bus15.CS_P = 1'b0; bus15.ADDR_Prog = '0; bus15.CS = 1'b0; bus15.WE = 1'b0;
        bus15.ADDR = '0; bus15.Data_BUS_WRITE = '0; bus15.mem_rdata = '0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_we_ignored();
        test_contention();
        test_drop();
        test_reset_busy();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
